// File: rtl/mig_chain_eval_if.sv
// Bundle of config, control and result signals for mig_chain_eval.
// Defining MIG_TT_COMPARE_EN adds the tt_expect / match pair.
interface mig_chain_eval_if #(
  parameter int NIN    = 4,
  parameter int NGATES = 6
);
  localparam int TW = 1 << NIN;
  localparam int SW = $clog2(1 + NIN + NGATES);
  localparam int FW = SW + 1;
  localparam int AW = $clog2(NGATES + 1);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [3*FW-1:0] cfg_data;
  logic          cfg_err;
  logic          start;
  logic          busy;
  logic          done;
  logic [TW-1:0] tt;
`ifdef MIG_TT_COMPARE_EN
  logic [TW-1:0] tt_expect;
  logic          match;

  modport master (output cfg_we, cfg_addr, cfg_data, start, tt_expect,
                  input  cfg_err, busy, done, tt, match);
  modport slave  (input  cfg_we, cfg_addr, cfg_data, start, tt_expect,
                  output cfg_err, busy, done, tt, match);
`else
  modport master (output cfg_we, cfg_addr, cfg_data, start,
                  input  cfg_err, busy, done, tt);
  modport slave  (input  cfg_we, cfg_addr, cfg_data, start,
                  output cfg_err, busy, done, tt);
`endif
endinterface

// File: rtl/mig_chain_eval.sv
// Run-time programmable majority-inverter chain; sweeps all minterms, one per cycle, into tt.
// Optional MIG_TT_COMPARE_EN adds a registered tt == tt_expect flag.
module mig_chain_eval #(
  parameter int NIN    = 4,
  parameter int NGATES = 6
) (
  input logic             clk,
  input logic             rst,
  mig_chain_eval_if.slave bus
);
  localparam int TW = 1 << NIN;
  localparam int SW = $clog2(1 + NIN + NGATES);
  localparam int FW = SW + 1;
  localparam int AW = $clog2(NGATES + 1);
  localparam int LW = SW + 1;
  localparam int MW = NIN + 1;
  localparam int NS = 1 << SW;
  localparam logic [AW-1:0] OUT_ADDR = AW'(NGATES);
  localparam logic [MW-1:0] M_LAST   = MW'(TW - 1);
  localparam logic [LW-1:0] X_BASE   = LW'(NIN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [MW-1:0]   m;
  logic [3*FW-1:0] cfg [NGATES+1];
  logic            out_bit;
  logic            bad;
  logic [LW-1:0]   lim;
  logic [TW-1:0]   tt_nxt;

  // Signals are built up in index order, so each gate only sees earlier ones.
  always_comb begin : eval
    logic [NS-1:0] s;
    logic a, b, c;
    s = '0;
    s[NIN:1] = m[NIN-1:0];
    for (int j = 0; j < NGATES; j++) begin
      a = s[cfg[j][SW-1:0]]       ^ cfg[j][FW-1];
      b = s[cfg[j][FW +: SW]]     ^ cfg[j][2*FW-1];
      c = s[cfg[j][2*FW +: SW]]   ^ cfg[j][3*FW-1];
      s[NIN+1+j] = (a & b) | (a & c) | (b & c);
    end
    out_bit = s[cfg[NGATES][SW-1:0]] ^ cfg[NGATES][FW-1];
  end

  always_comb begin
    tt_nxt = bus.tt;
    tt_nxt[m[NIN-1:0]] = out_bit;
  end

  // The output selector's limit falls out of the same formula with addr = NGATES.
  always_comb begin
    lim = X_BASE + LW'(bus.cfg_addr);
    bad = (bus.cfg_addr > OUT_ADDR) || (state == RUN);
    for (int f = 0; f < 3; f++) begin
      if ((f == 0 || bus.cfg_addr != OUT_ADDR) &&
          ({1'b0, bus.cfg_data[f*FW +: SW]} >= lim))
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      m           <= '0;
      bus.tt      <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.cfg_err <= 1'b0;
      for (int k = 0; k <= NGATES; k++) cfg[k] <= '0;
`ifdef MIG_TT_COMPARE_EN
      bus.match   <= 1'b0;
`endif
    end else begin
      bus.cfg_err <= bus.cfg_we && bad;
      if (bus.cfg_we && !bad) cfg[bus.cfg_addr] <= bus.cfg_data;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            m        <= '0;
            bus.tt   <= '0;
            bus.busy <= 1'b1;
`ifdef MIG_TT_COMPARE_EN
            bus.match <= 1'b0;
`endif
          end
        end
        RUN: begin
          bus.tt <= tt_nxt;
          if (m == M_LAST) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
`ifdef MIG_TT_COMPARE_EN
            bus.match <= (tt_nxt == bus.tt_expect);
`endif
          end else begin
            m <= m + 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mig_chain_eval.md
Name: mig_chain_eval

Overview:
- Programmable majority-inverter chain evaluator: the parametrised, sequential successor of our fixed 4-input exact-synthesis netlists.
- Holds a run-time-loaded chain of NGATES three-input majority nodes with complementable fanins over NIN primary inputs.
- On start, sweeps all 2^NIN minterms, one per cycle, and returns the realised truth table.
- Used by the exact-synthesis flow to check candidate chains in hardware without regenerating a netlist per function.

Parameters:
- NIN, 4, number of primary inputs (2..6); truth table width TW = 2^NIN.
- NGATES, 6, number of majority nodes in the chain (1..16).
- Derived SW = clog2(1+NIN+NGATES): select width. FW = SW+1: fanin field width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  clog2(NGATES+1)  0..NGATES-1 = gate index; NGATES = output selector
- cfg_data  in  3*FW  three fanin fields; field f = cfg_data[f*FW +: FW]; bit FW-1 = complement, low SW bits = signal select
- cfg_err  out  1  one-cycle pulse: the previous-cycle write was rejected
- start  in  1  begin evaluation (sampled in IDLE only)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, truth table complete
- tt  out  TW  truth table; bit m = output for minterm m

Behaviour:
- Signal index space:
  - 0 = constant 0.
  - 1..NIN = x0..x(NIN-1), where x_k = bit k of the minterm counter m.
  - NIN+1+j = output of gate j.
- Gate j = MAJ(a,b,c); each operand is the selected signal XOR its complement bit.
- Output = field 0 of the output selector (its select + complement); fields 1 and 2 are ignored.
- Config write, accepted in IDLE or DONE only. A write is rejected when:
  - cfg_addr > NGATES; or
  - any used field selects an index >= NIN+1+cfg_addr (forward or self reference; for the output selector the limit is NIN+1+NGATES); or
  - busy = 1.
- A rejected write leaves storage unchanged and pulses cfg_err in the next cycle.
- Reset values:
  - all config fields zero, so every gate is MAJ(0,0,0) and the output selects constant 0;
  - tt = 0, busy = 0, done = 0, cfg_err = 0;
  - m = 0, FSM in IDLE.
- FSM, states IDLE, RUN, DONE:
  - IDLE: start=1 -> RUN, m <= 0, tt <= 0.
  - RUN: each cycle the chain is evaluated combinationally for m, and tt[m] is registered. If m = TW-1, go to DONE; otherwise m <= m+1.
  - DONE: done = 1 for exactly one cycle -> IDLE.
- Timing: with start sampled at edge 0, RUN lasts edges 1..TW and done is high in the cycle after edge TW.
- tt holds its value from DONE until the next accepted start, which clears it.
- start in RUN or DONE is ignored, not queued.
- A simultaneous cfg_we and start in IDLE: the write is applied first and the run uses the new config.
- Reset in any state returns to IDLE with all reset values, including cleared config.
- m is NIN+1 bits wide internally so the terminal-count compare cannot wrap.

Optional Feature:
- Macro MIG_TT_COMPARE_EN.
- When defined, adds:
  - input tt_expect[TW];
  - output match, registered, reset 0.
- match is updated in the DONE cycle to (tt == tt_expect) and holds until the next accepted start, which clears it.
- When undefined, neither port exists and the comparator logic is absent.

Test Plan:
- Reset, then start with NIN=4, NGATES=6 -> busy for 16 cycles, done pulse, tt=16'h0000.
- Gate0 = MAJ(x0,x1,x2) (selects 1,2,3), output = index 5 -> tt=16'hE8E8.
- Gate0 = MAJ(x0,x3,0), output = ~index 5 -> tt=16'h55FF. Then reconfigure gate0 = MAJ(x1,x2,~0) with uncomplemented output -> tt=16'hFCFC.
- Gate2 fanin selecting index 7 (itself) -> cfg_err pulse. A cfg_addr=7 write -> cfg_err. A following run still returns the prior tt.
- During RUN: assert cfg_we and start -> cfg_err pulse, no restart, tt unchanged. Assert rst at m=9 -> busy=0, tt=0, config cleared.
- With MIG_TT_COMPARE_EN defined, the MAJ(x0,x1,x2) config:
  - tt_expect=16'hE8E8 -> match=1 in the DONE cycle;
  - tt_expect=16'hE8E9 -> match=0.
